// File: rtl/replica_pkg.sv
// Shared types and sizing for the replica-exchange datapath.
// Each node keeps one distance total and one city ordering per channel.
package replica_pkg;

    localparam int unsigned city_num     = 16;
    localparam int unsigned city_num_log = 4;
    localparam int unsigned total_w      = 24;
    localparam int unsigned replica_w    = 8;

    typedef logic [total_w-1:0]   total_data_t;
    typedef logic [replica_w-1:0] replica_data_t;

    typedef enum logic [2:0] {
        StIdle,
        StTest,
        StSync,
        StStream,
        StCommit
    } exchange_state_t;

endpackage

// File: rtl/exchange_test.sv
// Metropolis acceptance test for one channel.
// Accepts on a non-positive energy delta, or when the scaled delta is below the random draw.
module exchange_test
    import replica_pkg::*;
(
    input  logic        enable,
    input  total_data_t self_dis,
    input  total_data_t partner_dis,
    input  logic [16:0] exp_recip,
    input  logic [15:0] rand_val,
    output logic        accept
);

    localparam int unsigned pw = total_w + 18;

    logic signed [total_w:0] delta;
    logic [pw-1:0]           product;
    logic                    non_positive;

    always_comb begin
        delta        = $signed({1'b0, partner_dis}) - $signed({1'b0, self_dis});
        non_positive = delta[total_w] || (delta == '0);
        product      = pw'(unsigned'(delta)) * pw'(exp_recip);
        // min(product >> 16, 16'hffff) < rand  is exactly  product < rand << 16
        accept       = enable && (non_positive || (product < pw'({rand_val, 16'h0000})));
    end

endmodule

// File: rtl/node_exchange.sv
// One node of the replica chain: decides swaps with its partner, streams the
// ordering across, and commits the partner distance on an accepted swap.
module node_exchange
    import replica_pkg::*;
#(
    parameter int          id      = 0,
    parameter int unsigned ch_num  = 2,
    parameter int unsigned ord_len = city_num,
    parameter bit          is_last = 1'b0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          ex_start,
    input  logic                          ex_phase,
    input  logic [16:0]                   exp_recip,
    input  logic [ch_num*16-1:0]          rand_in,
    input  logic [ch_num*total_w-1:0]     self_dis,
    input  logic [ch_num*total_w-1:0]     folw_dis,
    input  logic [ch_num*total_w-1:0]     prev_dis,
    input  logic [ch_num-1:0]             prev_exchange,
    output logic [ch_num-1:0]             out_exchange,
    output logic [city_num_log-1:0]       ord_raddr,
    input  logic [ch_num*replica_w-1:0]   ord_rdata,
    output logic                          out_ord_valid,
    output logic [ch_num*replica_w-1:0]   out_ord_data,
    input  logic                          prev_ord_valid,
    input  logic [ch_num*replica_w-1:0]   prev_ord_data,
    input  logic                          folw_ord_valid,
    input  logic [ch_num*replica_w-1:0]   folw_ord_data,
    output logic [ch_num-1:0]             ord_we,
    output logic [city_num_log-1:0]       ord_waddr,
    output logic [ch_num*replica_w-1:0]   ord_wdata,
    output logic [ch_num-1:0]             dis_we,
    output logic [ch_num*total_w-1:0]     new_dis,
    output logic                          busy,
    output logic                          ex_done
);

    localparam int unsigned cnt_w  = city_num_log + 1;
    localparam bit          id_odd = (id % 2) != 0;

    exchange_state_t state_q, state_d;
    logic [cnt_w-1:0]             cnt_q;
    logic                         lower_q;
    logic [ch_num-1:0]            decision_q;
    logic [ch_num*total_w-1:0]    partner_dis_q;

    logic [ch_num-1:0]            accept;
    logic [ch_num-1:0]            prev_ex_rot;
    logic [ch_num*total_w-1:0]    partner_dis;
    logic [ch_num*replica_w-1:0]  partner_word;
    logic                         partner_valid;
    logic                         test_en;

    assign test_en       = lower_q && !is_last;
    assign partner_valid = lower_q ? folw_ord_valid : prev_ord_valid;

    // Channel c pairs with neighbour channel (c+1) mod ch_num.
    for (genvar c = 0; c < ch_num; c++) begin : g_ch
        localparam int unsigned r = (c + 1) % ch_num;

        assign partner_dis[c*total_w +: total_w] = lower_q ? folw_dis[r*total_w +: total_w]
                                                           : prev_dis[r*total_w +: total_w];
        assign partner_word[c*replica_w +: replica_w] =
            lower_q ? folw_ord_data[r*replica_w +: replica_w]
                    : prev_ord_data[r*replica_w +: replica_w];
        assign prev_ex_rot[c] = prev_exchange[r];

        exchange_test u_test (
            .enable      (test_en),
            .self_dis    (self_dis[c*total_w +: total_w]),
            .partner_dis (partner_dis[c*total_w +: total_w]),
            .exp_recip   (exp_recip),
            .rand_val    (rand_in[c*16 +: 16]),
            .accept      (accept[c])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            lower_q       <= 1'b0;
            out_exchange  <= '0;
            decision_q    <= '0;
            partner_dis_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= (state_q == StStream) ? cnt_q + cnt_w'(1) : '0;
            if (state_q == StIdle && ex_start) begin
                lower_q      <= (id_odd == ex_phase);
                out_exchange <= '0;
            end
            if (state_q == StTest) begin
                out_exchange  <= accept;
                decision_q    <= accept;
                partner_dis_q <= partner_dis;
            end
            // Upper node adopts the decision its lower partner published at end of TEST.
            if (state_q == StSync && !lower_q) begin
                decision_q <= prev_ex_rot;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (ex_start) state_d = StTest;
            StTest:   state_d = StSync;
            StSync:   state_d = StStream;
            StStream: if (cnt_q == cnt_w'(ord_len)) state_d = StCommit;
            StCommit: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        busy          = (state_q != StIdle);
        ord_raddr     = '0;
        out_ord_valid = 1'b0;
        out_ord_data  = ord_rdata;
        ord_we        = '0;
        ord_waddr     = '0;
        ord_wdata     = partner_word;
        dis_we        = '0;
        new_dis       = partner_dis_q;
        ex_done       = 1'b0;
        if (state_q == StStream) begin
            if (cnt_q < cnt_w'(ord_len)) ord_raddr = city_num_log'(cnt_q);
            if (cnt_q != '0) begin
                out_ord_valid = 1'b1;
                ord_waddr     = city_num_log'(cnt_q - cnt_w'(1));
                ord_we        = decision_q & {ch_num{partner_valid}};
            end
        end
        if (state_q == StCommit) begin
            dis_we  = decision_q;
            ex_done = 1'b1;
        end
    end

endmodule

// File: tb/tb_node_exchange.sv
// Directed bench for node_exchange: a two-channel node, an is_last node fed
// the same stimulus, and a three-channel node for the rotation mapping.
module tb_node_exchange;
    import replica_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        ex_start, ex_phase;
    logic [16:0] exp_recip;
    logic [31:0] rand_in;
    logic [47:0] self_dis, folw_dis, prev_dis;
    logic [1:0]  prev_exchange;
    logic [15:0] ord_rdata, prev_ord_data, folw_ord_data;
    logic        prev_ord_valid, folw_ord_valid;

    logic [1:0]  oe_m, we_m, dwe_m, oe_l, we_l, dwe_l;
    logic [3:0]  raddr_m, waddr_m, raddr_l, waddr_l;
    logic        ov_m, ov_l, busy_m, busy_l, done_m, done_l;
    logic [15:0] od_m, wd_m, od_l, wd_l;
    logic [47:0] nd_m, nd_l;

    logic [47:0] rand3;
    logic [71:0] self3, folw3, prev3;
    logic [2:0]  pex3, oe_t, we_t, dwe_t;
    logic [23:0] zero24, od_t, wd_t;
    logic [3:0]  raddr_t, waddr_t;
    logic        ov_t, busy_t, done_t;
    logic [71:0] nd_t;

    int n_checks = 0;
    int n_pass = 0;

    int we_cnt_m0, we_cnt_m1, we_cnt_l, data_err, ov_cnt, busy_cnt, done_at_m, done_at_l;
    logic [1:0]  obs_oe_m, obs_oe_l, obs_dwe_m, obs_dwe_l;
    logic [2:0]  obs_oe_t;
    logic [47:0] obs_nd_m;

    node_exchange u_main (
        .clk(clk), .reset(reset), .ex_start(ex_start), .ex_phase(ex_phase),
        .exp_recip(exp_recip), .rand_in(rand_in), .self_dis(self_dis), .folw_dis(folw_dis),
        .prev_dis(prev_dis), .prev_exchange(prev_exchange), .out_exchange(oe_m),
        .ord_raddr(raddr_m), .ord_rdata(ord_rdata), .out_ord_valid(ov_m), .out_ord_data(od_m),
        .prev_ord_valid(prev_ord_valid), .prev_ord_data(prev_ord_data),
        .folw_ord_valid(folw_ord_valid), .folw_ord_data(folw_ord_data), .ord_we(we_m),
        .ord_waddr(waddr_m), .ord_wdata(wd_m), .dis_we(dwe_m), .new_dis(nd_m),
        .busy(busy_m), .ex_done(done_m)
    );

    node_exchange #(.is_last(1'b1)) u_last (
        .clk(clk), .reset(reset), .ex_start(ex_start), .ex_phase(ex_phase),
        .exp_recip(exp_recip), .rand_in(rand_in), .self_dis(self_dis), .folw_dis(folw_dis),
        .prev_dis(prev_dis), .prev_exchange(prev_exchange), .out_exchange(oe_l),
        .ord_raddr(raddr_l), .ord_rdata(ord_rdata), .out_ord_valid(ov_l), .out_ord_data(od_l),
        .prev_ord_valid(prev_ord_valid), .prev_ord_data(prev_ord_data),
        .folw_ord_valid(folw_ord_valid), .folw_ord_data(folw_ord_data), .ord_we(we_l),
        .ord_waddr(waddr_l), .ord_wdata(wd_l), .dis_we(dwe_l), .new_dis(nd_l),
        .busy(busy_l), .ex_done(done_l)
    );

    node_exchange #(.ch_num(3)) u_tri (
        .clk(clk), .reset(reset), .ex_start(ex_start), .ex_phase(ex_phase),
        .exp_recip(exp_recip), .rand_in(rand3), .self_dis(self3), .folw_dis(folw3),
        .prev_dis(prev3), .prev_exchange(pex3), .out_exchange(oe_t),
        .ord_raddr(raddr_t), .ord_rdata(zero24), .out_ord_valid(ov_t), .out_ord_data(od_t),
        .prev_ord_valid(prev_ord_valid), .prev_ord_data(zero24),
        .folw_ord_valid(folw_ord_valid), .folw_ord_data(zero24), .ord_we(we_t),
        .ord_waddr(waddr_t), .ord_wdata(wd_t), .dis_we(dwe_t), .new_dis(nd_t),
        .busy(busy_t), .ex_done(done_t)
    );

    function automatic logic [7:0] ram_word(input logic c, input logic [3:0] a);
        return {1'b0, c, 2'b11, a};
    endfunction

    function automatic logic [7:0] strm_word(input logic src, input logic j, input logic [4:0] k);
        return {src, j, 1'b0, k};
    endfunction

    // Ordering RAM with one cycle of read latency.
    always @(posedge clk) ord_rdata <= {ram_word(1'b1, raddr_m), ram_word(1'b0, raddr_m)};

    // Pulses ex_start, drives both partner streams, and records what the nodes do.
    task automatic run_round(input logic phase, input int skip_k);
        int k;
        logic [4:0] kk;
        logic lower;
        logic [7:0] exp_w;
        lower = (phase == 1'b0);
        we_cnt_m0 = 0; we_cnt_m1 = 0; we_cnt_l = 0; data_err = 0; ov_cnt = 0; busy_cnt = 0;
        done_at_m = -1; done_at_l = -1;
        obs_dwe_m = '0; obs_dwe_l = '0; obs_nd_m = '0;
        ex_phase = phase; ex_start = 1'b1;
        folw_ord_valid = 1'b0; prev_ord_valid = 1'b0;
        @(posedge clk); #1;
        ex_start = 1'b0;
        for (int n = 1; n <= 22; n++) begin
            k = n - 3;
            kk = 5'(k);
            folw_ord_valid = (k >= 1 && k <= 16 && k != skip_k);
            prev_ord_valid = folw_ord_valid;
            folw_ord_data = {strm_word(1'b1, 1'b1, kk), strm_word(1'b1, 1'b0, kk)};
            prev_ord_data = {strm_word(1'b0, 1'b1, kk), strm_word(1'b0, 1'b0, kk)};
            #1;
            if (n == 2) begin obs_oe_m = oe_m; obs_oe_l = oe_l; obs_oe_t = oe_t; end
            if (busy_m) busy_cnt++;
            for (int c = 0; c < 2; c++) begin
                if (we_m[c]) begin
                    if (c == 0) we_cnt_m0++; else we_cnt_m1++;
                    exp_w = strm_word(lower, (c == 0), kk);
                    if (waddr_m !== 4'(k - 1) || wd_m[c*8 +: 8] !== exp_w) data_err++;
                end
                if (we_l[c]) we_cnt_l++;
            end
            if (ov_m) begin
                ov_cnt++;
                if (od_m !== {ram_word(1'b1, 4'(k - 1)), ram_word(1'b0, 4'(k - 1))}) data_err++;
            end
            if (dwe_m != '0) begin obs_dwe_m = dwe_m; obs_nd_m = nd_m; end
            if (dwe_l != '0) obs_dwe_l = dwe_l;
            if (done_m) done_at_m = n;
            if (done_l) done_at_l = n;
            @(posedge clk); #1;
        end
        folw_ord_valid = 1'b0; prev_ord_valid = 1'b0;
    endtask

    task automatic set_lower_accept();
        exp_recip = 17'h10000;
        rand_in = '0;
        self_dis = {24'd1000, 24'd1000};
        folw_dis = {24'd950, 24'd900};
        prev_dis = {24'd10, 24'd20};
        prev_exchange = 2'b00;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (busy_m !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy_m); else n_pass++;
        n_checks++; if ({oe_m, we_m, dwe_m} !== 6'b0) $display("FAIL reset_strobes: got %b want 0", {oe_m, we_m, dwe_m}); else n_pass++;
        n_checks++; if ({ov_m, done_m, raddr_m} !== 6'b0) $display("FAIL reset_stream: got %b want 0", {ov_m, done_m, raddr_m}); else n_pass++;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (busy_m !== 1'b0) $display("FAIL idle_no_start: got %b want 0", busy_m); else n_pass++;
    endtask

    task automatic test_lower_accept();
        set_lower_accept();
        run_round(1'b0, 0);
        n_checks++; if (obs_oe_m !== 2'b11) $display("FAIL lower_oe: got %b want 11", obs_oe_m); else n_pass++;
        n_checks++; if (we_cnt_m0 !== 16 || we_cnt_m1 !== 16) $display("FAIL lower_we_cnt: got %0d,%0d want 16,16", we_cnt_m0, we_cnt_m1); else n_pass++;
        n_checks++; if (data_err !== 0) $display("FAIL lower_words: got %0d bad want 0", data_err); else n_pass++;
        n_checks++; if (ov_cnt !== 16) $display("FAIL lower_out_valid: got %0d want 16", ov_cnt); else n_pass++;
        n_checks++; if (obs_dwe_m !== 2'b11) $display("FAIL lower_dis_we: got %b want 11", obs_dwe_m); else n_pass++;
        n_checks++; if (obs_nd_m !== {24'd900, 24'd950}) $display("FAIL lower_new_dis: got %h want %h", obs_nd_m, {24'd900, 24'd950}); else n_pass++;
        n_checks++; if (done_at_m !== 20) $display("FAIL lower_latency: got %0d want 20", done_at_m); else n_pass++;
        n_checks++; if (busy_cnt !== 20) $display("FAIL lower_busy: got %0d want 20", busy_cnt); else n_pass++;
    endtask

    task automatic test_metric();
        set_lower_accept();
        self_dis = {24'd1000, 24'd1000};
        folw_dis = {24'd1100, 24'd1100};
        rand_in = {16'd101, 16'd99};
        run_round(1'b0, 0);
        n_checks++; if (obs_oe_m !== 2'b10) $display("FAIL metric_oe: got %b want 10", obs_oe_m); else n_pass++;
        n_checks++; if (we_cnt_m0 !== 0 || we_cnt_m1 !== 16) $display("FAIL metric_we_cnt: got %0d,%0d want 0,16", we_cnt_m0, we_cnt_m1); else n_pass++;
        n_checks++; if (obs_dwe_m !== 2'b10) $display("FAIL metric_dis_we: got %b want 10", obs_dwe_m); else n_pass++;
        n_checks++; if (obs_nd_m[47:24] !== 24'd1100) $display("FAIL metric_new_dis: got %0d want 1100", obs_nd_m[47:24]); else n_pass++;
    endtask

    task automatic test_rotation3();
        set_lower_accept();
        self3 = {24'd1000, 24'd1000, 24'd1000};
        folw3 = {24'd1100, 24'd1100, 24'd900};
        prev3 = '0;
        pex3 = '0;
        rand3 = {16'd0, 16'd200, 16'd50};
        run_round(1'b0, 0);
        n_checks++; if (obs_oe_t !== 3'b110) $display("FAIL rot3_oe: got %b want 110", obs_oe_t); else n_pass++;
    endtask

    task automatic test_upper();
        set_lower_accept();
        prev_dis = {24'd800, 24'd700};
        prev_exchange = 2'b10;
        run_round(1'b1, 0);
        n_checks++; if (obs_oe_m !== 2'b00) $display("FAIL upper_oe: got %b want 00", obs_oe_m); else n_pass++;
        n_checks++; if (we_cnt_m0 !== 16 || we_cnt_m1 !== 0) $display("FAIL upper_we_cnt: got %0d,%0d want 16,0", we_cnt_m0, we_cnt_m1); else n_pass++;
        n_checks++; if (data_err !== 0) $display("FAIL upper_words: got %0d bad want 0", data_err); else n_pass++;
        n_checks++; if (obs_dwe_m !== 2'b01) $display("FAIL upper_dis_we: got %b want 01", obs_dwe_m); else n_pass++;
        n_checks++; if (obs_nd_m[23:0] !== 24'd800) $display("FAIL upper_new_dis: got %0d want 800", obs_nd_m[23:0]); else n_pass++;
        n_checks++; if (done_at_m !== 20) $display("FAIL upper_latency: got %0d want 20", done_at_m); else n_pass++;
    endtask

    task automatic test_skip();
        set_lower_accept();
        run_round(1'b0, 7);
        n_checks++; if (we_cnt_m0 !== 15 || we_cnt_m1 !== 15) $display("FAIL skip_we_cnt: got %0d,%0d want 15,15", we_cnt_m0, we_cnt_m1); else n_pass++;
        n_checks++; if (done_at_m !== 20) $display("FAIL skip_latency: got %0d want 20", done_at_m); else n_pass++;
    endtask

    task automatic test_is_last();
        set_lower_accept();
        run_round(1'b0, 0);
        n_checks++; if (obs_oe_l !== 2'b00) $display("FAIL last_oe: got %b want 00", obs_oe_l); else n_pass++;
        n_checks++; if (we_cnt_l !== 0) $display("FAIL last_we: got %0d want 0", we_cnt_l); else n_pass++;
        n_checks++; if (obs_dwe_l !== 2'b00) $display("FAIL last_dis_we: got %b want 00", obs_dwe_l); else n_pass++;
        n_checks++; if (done_at_l !== 20) $display("FAIL last_done: got %0d want 20", done_at_l); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int dwe_seen;
        set_lower_accept();
        dwe_seen = 0;
        ex_phase = 1'b0; ex_start = 1'b1;
        @(posedge clk); #1;
        ex_start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        n_checks++; if (ov_m !== 1'b1 || raddr_m !== 4'd5) $display("FAIL mid_in_stream: got %b/%0d want 1/5", ov_m, raddr_m); else n_pass++;
        reset = 1'b1;
        #1;
        n_checks++; if ({busy_m, ov_m, done_m} !== 3'b000) $display("FAIL mid_reset_ctl: got %b want 000", {busy_m, ov_m, done_m}); else n_pass++;
        n_checks++; if ({oe_m, we_m, dwe_m, raddr_m} !== 10'b0) $display("FAIL mid_reset_out: got %b want 0", {oe_m, we_m, dwe_m, raddr_m}); else n_pass++;
        repeat (3) begin
            @(posedge clk); #1;
            if (dwe_m != '0) dwe_seen++;
        end
        reset = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            if (dwe_m != '0) dwe_seen++;
        end
        n_checks++; if (dwe_seen !== 0) $display("FAIL mid_no_commit: got %0d want 0", dwe_seen); else n_pass++;
        run_round(1'b0, 0);
        n_checks++; if (done_at_m !== 20 || obs_dwe_m !== 2'b11) $display("FAIL mid_rerun: got %0d/%b want 20/11", done_at_m, obs_dwe_m); else n_pass++;
        n_checks++; if (we_cnt_m0 !== 16 || we_cnt_m1 !== 16) $display("FAIL mid_rerun_we: got %0d,%0d want 16,16", we_cnt_m0, we_cnt_m1); else n_pass++;
    endtask

    initial begin
        zero24 = '0;
        ex_start = 1'b0; ex_phase = 1'b0;
        folw_ord_valid = 1'b0; prev_ord_valid = 1'b0;
        folw_ord_data = '0; prev_ord_data = '0;
        self3 = '0; folw3 = '0; prev3 = '0; pex3 = '0; rand3 = '0;
        set_lower_accept();
        test_reset();
        test_lower_accept();
        test_metric();
        test_rotation3();
        test_upper();
        test_skip();
        test_is_last();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
